// File: rtl/pc_if.sv
// Control/datapath side of the program counter: load/increment requests,
// branch target in, current instruction address out.
interface pc_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  PC_Load;
    logic                  PC_Inc;
    logic [ADDR_WIDTH-1:0] Dest_Reg;
    logic [ADDR_WIDTH-1:0] PC_Out;

    modport master (
        output PC_Load,
        output PC_Inc,
        output Dest_Reg,
        input  PC_Out
    );

    modport slave (
        input  PC_Load,
        input  PC_Inc,
        input  Dest_Reg,
        output PC_Out
    );
endinterface

// File: rtl/pc.sv
// Program counter: asynchronous clear, then per-edge priority load > increment > hold.
// PC_Out comes straight from the state register.
module pc #(
    parameter int unsigned              ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic Clk,
    input  logic PC_Clr,
    pc_if.slave  bus
);
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Next address; increment wraps naturally at the register width.
    always_comb begin
        pc_d = pc_q;
        if (bus.PC_Load) begin
            pc_d = bus.Dest_Reg;
        end else if (bus.PC_Inc) begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge PC_Clr) begin
        if (!PC_Clr) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.PC_Out = pc_q;
endmodule

// File: tb/tb_pc.sv
// Randomized self-checking bench for pc against an arithmetic reference model.
module tb_pc;
    localparam int unsigned    AW = 8;
    localparam logic [AW-1:0]  RV = '0;
    localparam int             MODULUS = 1 << AW;

    logic Clk = 1'b0;
    logic PC_Clr;
    int   checks = 0;
    int   errors = 0;
    int   ref_pc = 0;

    pc_if #(.ADDR_WIDTH(AW)) bus ();

    pc #(.ADDR_WIDTH(AW), .RESET_VALUE(RV)) dut (
        .Clk    (Clk),
        .PC_Clr (PC_Clr),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs; a low clear takes the model to RESET_VALUE immediately.
    task automatic drive(input logic clr, input logic load, input logic inc, input logic [AW-1:0] d);
        PC_Clr       = clr;
        bus.PC_Load  = load;
        bus.PC_Inc   = inc;
        bus.Dest_Reg = d;
        if (!clr) ref_pc = int'(RV);
    endtask

    // Advance one edge, update the model from the sampled inputs, compare.
    task automatic tick(input string tag);
        @(posedge Clk);
        #1;
        if (PC_Clr) begin
            if (bus.PC_Load)     ref_pc = int'(bus.Dest_Reg);
            else if (bus.PC_Inc) ref_pc = (ref_pc + 1) % MODULUS;
        end
        check_eq(tag, bus.PC_Out, AW'(ref_pc));
    endtask

    initial begin
        // Clear held with a load pending
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        #1;
        check_eq("clr_async_start", bus.PC_Out, RV);
        tick("clr_hold");
        tick("clr_hold");

        // Release does not change the counter by itself
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        check_eq("clr_release", bus.PC_Out, RV);

        drive(1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick("inc_run");
            check_eq("inc_run_abs", bus.PC_Out, AW'(i + 1));
        end

        // Mid-cycle clear from a nonzero value, then clear beats a pending op
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        tick("load_33");
        #2;
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        #1;
        check_eq("clr_mid_cycle", bus.PC_Out, RV);
        drive(1'b1, 1'b1, 1'b1, 8'hAA);
        #1;
        drive(1'b0, 1'b1, 1'b1, 8'hAA);
        tick("clr_wins");

        // Load priority over increment
        drive(1'b1, 1'b1, 1'b0, 8'h10);
        tick("load_10");
        drive(1'b1, 1'b1, 1'b1, 8'hC3);
        tick("load_prio");
        check_eq("load_prio_abs", bus.PC_Out, 8'hC3);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        tick("inc_after_load");
        check_eq("inc_after_load_abs", bus.PC_Out, 8'hC4);

        // Wrap-around
        drive(1'b1, 1'b1, 1'b0, 8'hFF);
        tick("load_ff");
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        tick("wrap");
        check_eq("wrap_abs", bus.PC_Out, 8'h00);
        tick("wrap_next");

        // Hold with Dest_Reg wiggling between edges
        drive(1'b1, 1'b1, 1'b0, 8'h42);
        tick("load_42");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, AW'($urandom));
            #2;
            bus.Dest_Reg = AW'($urandom);
            tick("hold");
            check_eq("hold_abs", bus.PC_Out, 8'h42);
        end

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), AW'($urandom));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc.md
Name: pc

Overview:
- Program counter for the simple microprocessor. Holds the address of the current instruction.
- Supports clear, parallel load of a jump/branch target, and increment.
- Sits between the control unit, which drives PC_Load and PC_Inc, and instruction memory, which is addressed by PC_Out.
- Dest_Reg carries the branch/jump target from the datapath.

Parameters:
- ADDR_WIDTH, default 8: width of the address held, loaded and output.
- RESET_VALUE, default 0: value forced onto the counter by clear. Must fit in ADDR_WIDTH bits.

Ports:
- Clk  input  1  system clock; all synchronous updates occur on its rising edge.
- PC_Clr  input  1  asynchronous, active-low clear (reset). 0 forces the counter to RESET_VALUE immediately, independent of Clk.
- PC_Load  input  1  synchronous load enable, active-high.
- PC_Inc  input  1  synchronous increment enable, active-high.
- Dest_Reg  input  ADDR_WIDTH  target address captured when a load occurs.
- PC_Out  output  ADDR_WIDTH  current counter value, driven directly from the state register (no combinational path from inputs).

Behaviour:
- Single state register pc_q of ADDR_WIDTH bits; PC_Out = pc_q at all times.
- Clear:
  - While PC_Clr = 0, pc_q = RESET_VALUE.
  - The effect is asynchronous: PC_Out changes without waiting for a clock edge.
  - Clock edges are ignored while clear is held.
- Clear release:
  - PC_Clr 0->1 does not change pc_q.
  - The first update is on the first rising Clk edge with PC_Clr = 1.
- On each rising Clk edge with PC_Clr = 1, priority is (highest first):
  - PC_Load = 1: pc_q <= Dest_Reg. PC_Inc is ignored.
  - PC_Load = 0, PC_Inc = 1: pc_q <= pc_q + 1, modulo 2^ADDR_WIDTH.
  - PC_Load = 0, PC_Inc = 0: pc_q holds.
- Latency: one clock. A load or increment requested in cycle N is visible on PC_Out after the rising edge ending cycle N.
- Wrap-around: from all-ones, an increment gives 0. No carry or overflow indication; no saturation.
- Load of any value, including all-ones and RESET_VALUE, is legal and takes effect exactly as for any other value.
- Load and increment asserted together: load wins; the loaded value is not incremented in the same cycle.
- Clear asserted mid-cycle, coincident with a pending load/increment: clear wins. The pending operation is discarded, not deferred.
- Dest_Reg, PC_Load and PC_Inc are sampled only at the rising edge; changes between edges have no effect.
- No X propagation from unused inputs: Dest_Reg is don't-care unless PC_Load = 1 at the edge.
- Power-up value is undefined until the first clear. The system must assert PC_Clr = 0 at start-up.

Test Plan:
- Clear: hold PC_Clr=0 for 2 cycles with PC_Load=1, Dest_Reg=8'h5A -> PC_Out=0 throughout, and changes to 0 asynchronously when PC_Clr falls mid-cycle from a nonzero value (e.g. 8'h33).
- Increment run: after release, PC_Inc=1, PC_Load=0 for 5 edges -> PC_Out 1,2,3,4,5, each one clock after the edge.
- Load priority: pc=8'h10, PC_Load=1, PC_Inc=1, Dest_Reg=8'hC3 -> PC_Out=8'hC3 after one edge. Next edge with PC_Inc=1 only -> 8'hC4.
- Wrap: load 8'hFF, then PC_Inc=1 -> PC_Out=8'h00. Another increment -> 8'h01.
- Hold: pc=8'h42, PC_Load=0, PC_Inc=0 with Dest_Reg toggling randomly for 4 cycles -> PC_Out stays 8'h42.
- Random regression: 1000 cycles of random PC_Clr/PC_Load/PC_Inc/Dest_Reg compared cycle-by-cycle against a reference model with priority Clr > Load > Inc > hold.
